// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and constants for the pattern sequencer.
package seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    localparam logic [3:0] BCD_LIMIT = 4'd10;
endpackage

// File: rtl/pattern_sequencer_if.sv
// pattern_sequencer_if: control, status and memory-side signals of the pattern sequencer.
interface pattern_sequencer_if #(parameter int ADDR_W = 4, parameter int WRAP_W = 8);
    logic                   start;
    logic                   stop;
    logic                   pause;
    logic                   loop_en;
    logic [ADDR_W-1:0]      limit;
    logic [2**ADDR_W-1:0]   mem_data;
    logic [ADDR_W-1:0]      addr;
    logic                   bit_out;
    logic                   bit_valid;
    logic                   busy;
    logic                   done;
    logic [WRAP_W-1:0]      wrap_cnt;
    modport master (output start, stop, pause, loop_en, limit, mem_data,
                    input addr, bit_out, bit_valid, busy, done, wrap_cnt);
    modport slave (input start, stop, pause, loop_en, limit, mem_data,
                   output addr, bit_out, bit_valid, busy, done, wrap_cnt);
endinterface

// File: rtl/seq_addr_counter.sv
// seq_addr_counter: address up-counter with limit latch, hold, clear and terminal/wrap detection.
module seq_addr_counter #(parameter int ADDR_W = 4) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clr,
    input  logic              inc,
    input  logic              wrap_en,
    input  logic [ADDR_W-1:0] limit,
    output logic [ADDR_W-1:0] addr,
    output logic              at_term,
    output logic              wrap
);
    logic [ADDR_W-1:0] limit_q;
    // limit 0 underflows to all-ones, which selects full depth for free
    assign at_term = addr == ADDR_W'(limit_q - 1'b1);
    assign wrap = inc && at_term && wrap_en;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr    <= '0;
            limit_q <= '0;
        end else if (load) begin
            addr    <= '0;
            limit_q <= limit;
        end else if (clr) begin
            addr <= '0;
        end else if (inc) begin
            addr <= at_term ? (wrap_en ? '0 : addr) : addr + 1'b1;
        end
    end
endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: start/stop/pause address sequencer driving the pattern memory and
// registering the selected bit as a serial stream.
module pattern_sequencer import seq_pkg::*; #(
    parameter int ADDR_W = 4,
    parameter int WRAP_W = 8
) (
    input logic clk,
    input logic rst_n,
    pattern_sequencer_if.slave bus
);
    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              at_term, wrap, load, clr, adv, finish;
    logic              bit_out, bit_valid, done;
    assign load   = state == IDLE && bus.start;
    assign adv    = state == RUN && !bus.stop && !bus.pause;
    assign finish = adv && at_term && !bus.loop_en;
    assign clr    = state == DONE || ((state == RUN || state == PAUSE) && bus.stop);
    seq_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .clr     (clr),
        .inc     (adv),
        .wrap_en (bus.loop_en),
        .limit   (bus.limit),
        .addr    (addr),
        .at_term (at_term),
        .wrap    (wrap)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            done      <= 1'b0;
            wrap_cnt  <= '0;
        end else begin
            bit_valid <= adv;
            done      <= finish;
            if (adv)
                bit_out <= bus.mem_data[addr];
            if (load)
                wrap_cnt <= '0;
            else if (wrap && wrap_cnt != '1)
                wrap_cnt <= wrap_cnt + 1'b1;
            case (state)
                IDLE:    state <= bus.start ? RUN : IDLE;
                RUN:     state <= bus.stop ? IDLE : bus.pause ? PAUSE : finish ? DONE : RUN;
                PAUSE:   state <= bus.stop ? IDLE : bus.pause ? PAUSE : RUN;
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.addr      = addr;
    assign bus.bit_out   = bit_out;
    assign bus.bit_valid = bit_valid;
    assign bus.busy      = state != IDLE;
    assign bus.done      = done;
    assign bus.wrap_cnt  = wrap_cnt;
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: scoreboard bench; expected bits are queued at stimulus time and
// popped whenever the sequencer presents a valid bit.
module tb_pattern_sequencer;
    import seq_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] pattern = 16'h1C3F;
    logic exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    pattern_sequencer_if #(.ADDR_W(4), .WRAP_W(8)) bus ();
    pattern_sequencer #(.ADDR_W(4), .WRAP_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign bus.mem_data = pattern;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push_bits(input int n, input int period);
        for (int i = 0; i < n; i++) exp_q.push_back(pattern[i % period]);
    endtask
    task automatic start_seq(input logic [3:0] lim, input logic loop);
        bus.limit = lim;
        bus.loop_en = loop;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask
    always @(negedge clk) begin
        if (rst_n && bus.bit_valid) begin
            if (exp_q.size() == 0) chk("extra_bit", 32'(bus.bit_valid), 32'd0);
            else chk("bit", 32'(bus.bit_out), 32'(exp_q.pop_front()));
        end
    end
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.loop_en = 0; bus.limit = '0;
        #2;
        chk("rst_addr", 32'(bus.addr), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_valid", 32'(bus.bit_valid), 0);
        chk("rst_wrap", 32'(bus.wrap_cnt), 0);
        #10 rst_n = 1'b1;
        tick();
        // reset mid-RUN at addr 7
        push_bits(7, 16);
        start_seq(4'd0, 1'b1);
        repeat (7) tick();
        chk("t1_addr7", 32'(bus.addr), 7);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_addr", 32'(bus.addr), 0);
        chk("t1_bit", 32'(bus.bit_out), 0);
        chk("t1_valid", 32'(bus.bit_valid), 0);
        chk("t1_busy", 32'(bus.busy), 0);
        chk("t1_done", 32'(bus.done), 0);
        #2 rst_n = 1'b1;
        repeat (2) tick();
        chk("t1_idle_busy", 32'(bus.busy), 0);
        chk("t1_idle_addr", 32'(bus.addr), 0);
        chk("t1_q", 32'(exp_q.size()), 0);
        // BCD-length single pass
        push_bits(10, 16);
        start_seq(BCD_LIMIT, 1'b0);
        chk("t2_addr0", 32'(bus.addr), 0);
        chk("t2_busy", 32'(bus.busy), 1);
        repeat (9) tick();
        chk("t2_addr9", 32'(bus.addr), 9);
        chk("t2_nodone", 32'(bus.done), 0);
        tick();
        chk("t2_done", 32'(bus.done), 1);
        chk("t2_busy_done", 32'(bus.busy), 1);
        tick();
        chk("t2_done_off", 32'(bus.done), 0);
        chk("t2_busy_off", 32'(bus.busy), 0);
        chk("t2_addr_clr", 32'(bus.addr), 0);
        chk("t2_q", 32'(exp_q.size()), 0);
        // looping 13-word sequence, limit change mid-run ignored
        for (int r = 0; r < 3; r++) push_bits(13, 13);
        start_seq(4'd13, 1'b1);
        bus.limit = 4'd4;
        repeat (39) tick();
        chk("t3_wrap", 32'(bus.wrap_cnt), 3);
        chk("t3_addr", 32'(bus.addr), 0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("t3_stop_busy", 32'(bus.busy), 0);
        chk("t3_wrap_hold", 32'(bus.wrap_cnt), 3);
        chk("t3_q", 32'(exp_q.size()), 0);
        // pause at addr 3 for 4 cycles
        push_bits(10, 16);
        start_seq(4'd10, 1'b0);
        chk("t4_wrap_clr", 32'(bus.wrap_cnt), 0);
        repeat (3) tick();
        bus.pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_hold_addr", 32'(bus.addr), 3);
            chk("t4_valid_low", 32'(bus.bit_valid), 0);
            chk("t4_busy", 32'(bus.busy), 1);
        end
        bus.pause = 1'b0;
        tick();
        chk("t4_resume_addr", 32'(bus.addr), 3);
        begin
            int n = 0;
            while (bus.done !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("t4_done", 32'(bus.done), 1);
        end
        tick();
        chk("t4_q", 32'(exp_q.size()), 0);
        // start while busy ignored, then stop+pause together at addr 5
        push_bits(5, 16);
        start_seq(4'd0, 1'b1);
        repeat (2) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t5_start_ign", 32'(bus.addr), 3);
        repeat (2) tick();
        chk("t5_addr5", 32'(bus.addr), 5);
        bus.stop = 1'b1;
        bus.pause = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.pause = 1'b0;
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_addr", 32'(bus.addr), 0);
        chk("t5_done", 32'(bus.done), 0);
        chk("t5_valid", 32'(bus.bit_valid), 0);
        tick();
        chk("t5_done2", 32'(bus.done), 0);
        chk("t5_q", 32'(exp_q.size()), 0);
        // full depth looping past wrap saturation
        push_bits(257 * 16, 16);
        start_seq(4'd0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk("t6_addr", 32'(bus.addr), 32'(i));
            tick();
        end
        chk("t6_wrap1", 32'(bus.wrap_cnt), 1);
        repeat (254 * 16) tick();
        chk("t6_wrap255", 32'(bus.wrap_cnt), 255);
        repeat (2 * 16) tick();
        chk("t6_wrap_sat", 32'(bus.wrap_cnt), 255);
        chk("t6_addr_end", 32'(bus.addr), 0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("t6_q", 32'(exp_q.size()), 0);
        // limit 1: wrap every cycle, then single-bit finish
        push_bits(5, 1);
        start_seq(4'd1, 1'b1);
        chk("t6b_wrap_clr", 32'(bus.wrap_cnt), 0);
        repeat (5) tick();
        chk("t6b_addr", 32'(bus.addr), 0);
        chk("t6b_wrap", 32'(bus.wrap_cnt), 5);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        push_bits(1, 1);
        start_seq(4'd1, 1'b0);
        tick();
        chk("t6c_done", 32'(bus.done), 1);
        tick();
        chk("t6c_busy", 32'(bus.busy), 0);
        chk("t6c_q", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
